soc_dmem_arbiter: RTL
=====================

SOC_DMEM_ARBITER -- requirements
Module: soc_dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10, word-address width of the data RAM port (depth 2**ADDR_W words of 16 bits).
REQ-002 Parameter MAX_WAIT, default 4, DMA wait cycles after which DMA gets priority (range 1..15).
REQ-003 Parameter INIT_EN, default 1, 1 = zero-fill the whole RAM after reset; 0 = skip the fill.
REQ-004 mclk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU access request; held until granted.
REQ-007 cpu_addr  in  ADDR_W  CPU word address.
REQ-008 cpu_wen  in  2  CPU byte write enables, active high; 2'b00 = read.
REQ-009 cpu_din  in  16  CPU write data.
REQ-010 cpu_gnt  out  1  CPU request accepted this cycle.
REQ-011 cpu_rvalid  out  1  CPU read data valid.
REQ-012 cpu_dout  out  16  CPU read data.
REQ-013 dma_req, dma_addr, dma_wen, dma_din, dma_gnt, dma_rvalid, dma_dout: same widths and meaning as the cpu_* ports, for the DMA master.
REQ-014 init_done  out  1  zero-fill complete; the arbiter accepts requests.
REQ-015 ram_ena  out  1  RAM enable, active high.
REQ-016 ram_wea  out  2  RAM byte write enables, active high.
REQ-017 ram_addra  out  ADDR_W  RAM address.
REQ-018 ram_dina  out  16  RAM write data.
REQ-019 ram_douta  in  16  RAM read data; valid one cycle after an enabled read.

Function
REQ-020 The FSM SHALL have three states: RST, INIT and RUN.
REQ-021 RST SHALL go to INIT on the first edge if INIT_EN=1, otherwise to RUN.
REQ-022 In INIT, an ADDR_W-bit counter SHALL start at 0 and the block SHALL drive ram_ena=1, ram_wea=2'b11, ram_addra=counter and ram_dina=16'h0000 every cycle.
REQ-023 In INIT, the counter SHALL increment every cycle; on the cycle it writes address 2**ADDR_W-1 the FSM SHALL go to RUN.
REQ-024 In INIT, all request inputs SHALL be ignored and both gnt outputs SHALL be 0.
REQ-025 init_done SHALL be 1 exactly while the FSM is in RUN.
REQ-026 In RUN, at most one gnt SHALL be asserted per cycle, and the grant SHALL be combinational in the same cycle as req.
REQ-027 Priority SHALL go to the CPU, except that the DMA SHALL win when the wait counter equals MAX_WAIT.
REQ-028 The 4-bit wait counter SHALL increment each cycle dma_req=1 and dma_gnt=0, saturating at MAX_WAIT; it SHALL clear to 0 when dma_gnt=1 or dma_req=0.
REQ-029 On a grant, ram_ena=1 and ram_addra, ram_wea and ram_dina SHALL equal the granted master's addr, wen and din in the same cycle.
REQ-030 With no grant, ram_ena=0 and ram_wea=2'b00; ram_addra and ram_dina are don't-care.
REQ-031 A granted read (wen=2'b00) SHALL assert that master's rvalid for exactly one cycle, on the next cycle.
REQ-032 A master's dout SHALL equal ram_douta when its rvalid=1 and 16'h0000 otherwise.
REQ-033 A granted write SHALL assert no rvalid.
REQ-034 Back-to-back grants SHALL be supported every cycle (throughput 1 access/cycle), so rvalid may be continuously high.
REQ-035 A partial write (wen=2'b01 or 2'b10) SHALL pass unchanged to ram_wea; the byte merge is done by the RAM.

Reset
REQ-036 While reset_n=0, the FSM SHALL be in RST with init counter=0 and wait counter=0.
REQ-037 While reset_n=0: cpu_gnt, dma_gnt, cpu_rvalid, dma_rvalid, init_done, ram_ena and ram_wea SHALL be 0, and cpu_dout, dma_dout, ram_addra and ram_dina SHALL be 0.
REQ-038 Reset asserted mid-INIT or mid-RUN SHALL abort immediately; a pending rvalid SHALL be dropped and the fill SHALL restart from address 0 after release.

Verification
REQ-039 ADDR_W=4, INIT_EN=1, release reset, no requests -> 16 consecutive cycles of ram_ena=1, wea=11, addresses 0..15, din=0; then init_done=1.
REQ-040 In RUN, cpu_req with addr=5, wen=11, din=A5A5; then a read of 5 -> cpu_gnt on both cycles; cpu_rvalid one cycle after the read with cpu_dout=A5A5.
REQ-041 cpu_req and dma_req held high continuously, MAX_WAIT=4 -> 4 CPU grants, then 1 DMA grant, and the pattern repeats.
REQ-042 Simultaneous CPU read and DMA read, wait=0 -> CPU granted; DMA granted the next cycle once cpu_req drops; each rvalid reaches only its own master.
REQ-043 DMA byte write with wen=10, din=1234 to an address holding 0000, then read -> dma_dout=1200.
REQ-044 Assert reset_n=0 at fill address 7, hold 2 cycles, release -> all outputs 0 during reset; the fill restarts at address 0.

Source files
------------

// File: rtl/soc_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : soc_dmem_arbiter
// Description : CPU/DMA arbiter for a single-port 16-bit data RAM with
//               post-reset zero-fill and starvation-bounded DMA priority.
// Revision    : 1.0 - initial release
// ============================================================================
module soc_dmem_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4,
  parameter int INIT_EN  = 1
) (
  input  logic              mclk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [1:0]        cpu_wen,
  input  logic [15:0]       cpu_din,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [15:0]       cpu_dout,
  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [1:0]        dma_wen,
  input  logic [15:0]       dma_din,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [15:0]       dma_dout,
  output logic              init_done,
  output logic              ram_ena,
  output logic [1:0]        ram_wea,
  output logic [ADDR_W-1:0] ram_addra,
  output logic [15:0]       ram_dina,
  input  logic [15:0]       ram_douta
);

  localparam logic [1:0]        ST_RST   = 2'd0;
  localparam logic [1:0]        ST_INIT  = 2'd1;
  localparam logic [1:0]        ST_RUN   = 2'd2;
  localparam logic [3:0]        WAIT_LIM = 4'(MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADR = {ADDR_W{1'b1}};

  logic [1:0]        state;
  logic [ADDR_W-1:0] init_cnt;
  logic [3:0]        wait_cnt;
  logic              dma_wins;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_RST;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_RST: begin
          state    <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
          init_cnt <= '0;
        end
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == LAST_ADR) begin
            state <= ST_RUN;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_RST;
      endcase
    end
  end

  // The wait counter only measures DMA starvation while arbitration is live.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_RUN && dma_req && !dma_gnt) begin
      if (wait_cnt != WAIT_LIM) begin
        wait_cnt <= wait_cnt + 4'd1;
      end
    end else begin
      wait_cnt <= 4'd0;
    end
  end

  always_comb begin
    dma_wins = dma_req && (!cpu_req || wait_cnt == WAIT_LIM);
    cpu_gnt  = 1'b0;
    dma_gnt  = 1'b0;
    if (state == ST_RUN) begin
      dma_gnt = dma_wins;
      cpu_gnt = cpu_req && !dma_wins;
    end
  end

  always_comb begin
    ram_ena   = 1'b0;
    ram_wea   = 2'b00;
    ram_addra = '0;
    ram_dina  = 16'h0000;
    if (state == ST_INIT) begin
      ram_ena   = 1'b1;
      ram_wea   = 2'b11;
      ram_addra = init_cnt;
    end else if (cpu_gnt) begin
      ram_ena   = 1'b1;
      ram_wea   = cpu_wen;
      ram_addra = cpu_addr;
      ram_dina  = cpu_din;
    end else if (dma_gnt) begin
      ram_ena   = 1'b1;
      ram_wea   = dma_wen;
      ram_addra = dma_addr;
      ram_dina  = dma_din;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && (cpu_wen == 2'b00);
      dma_rvalid <= dma_gnt && (dma_wen == 2'b00);
    end
  end

  assign init_done = (state == ST_RUN);
  assign cpu_dout  = cpu_rvalid ? ram_douta : 16'h0000;
  assign dma_dout  = dma_rvalid ? ram_douta : 16'h0000;

endmodule
`default_nettype wire
